bitty_ls_unit: RTL and testbench

//  Load/store execution stage for the bitty processor, directly downstream of the control unit.

---
 rtl/bitty_ls_unit_pkg.sv | 30 +++
 rtl/bitty_ls_unit_if.sv | 33 +++
 rtl/bitty_ls_timer.sv | 46 ++++
 rtl/bitty_ls_unit.sv | 160 ++++++++++++++++
 tb/tb_bitty_ls_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitty_ls_unit_pkg.sv
// -----------------------------------------------------------------------------
// bitty_ls_unit_pkg
// Shared definitions for the bitty load/store stage.
//  - ls_state_e    : load/store FSM state encoding (IDLE/BUSY/DONE/RELEASE)
//  - EN_LS_*       : en_ls operation codes. The control unit uses the same codes.
//  - LS_ADDR_BUS_W : width of the datapath operand bus that feeds ls_addr
//  - is_mem_op()   : true for the two en_ls codes that start a bus access
// -----------------------------------------------------------------------------
package bitty_ls_unit_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BUSY    = 2'b01,
      DONE    = 2'b10,
      RELEASE = 2'b11
   } ls_state_e;

   localparam logic [1:0] EN_LS_IDLE    = 2'b00;
   localparam logic [1:0] EN_LS_LOAD    = 2'b01;
   localparam logic [1:0] EN_LS_STORE   = 2'b10;
   localparam logic [1:0] EN_LS_ILLEGAL = 2'b11;

   // The operand bus is always register-wide; the data-memory address may be narrower.
   localparam int LS_ADDR_BUS_W = 16;

   function automatic logic is_mem_op(input logic [1:0] en);
      return (en == EN_LS_LOAD) || (en == EN_LS_STORE);
   endfunction

endpackage

// File: rtl/bitty_ls_unit_if.sv
// -----------------------------------------------------------------------------
// bitty_ls_unit_if
// Data-memory req/ack bus between the load/store unit (master) and memory (slave).
//  mem_req   master->slave  request, held until mem_ack is sampled
//  mem_we    master->slave  1 = write; stable while mem_req = 1
//  mem_addr  master->slave  word address; stable while mem_req = 1
//  mem_wdata master->slave  write data; stable while mem_req = 1
//  mem_rdata slave->master  read data, valid with mem_ack on a read
//  mem_ack   slave->master  transaction complete; may rise with mem_req
// -----------------------------------------------------------------------------
interface bitty_ls_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) ();

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/bitty_ls_timer.sv
// -----------------------------------------------------------------------------
// bitty_ls_timer
// Clear/enable saturating cycle counter with an expiry flag.
//  clk     in   clock
//  reset   in   synchronous, active-low reset (count -> 0)
//  clr     in   force count to 0 (has priority over en)
//  en      in   count up by one, stopping at LIMIT
//  expired out  count == LIMIT; held low when ENABLE = 0
// -----------------------------------------------------------------------------
module bitty_ls_timer #(
   parameter int LIMIT  = 254,
   parameter bit ENABLE = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != LIMIT_V)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = ENABLE && (count_q == LIMIT_V);

endmodule

// File: rtl/bitty_ls_unit.sv
// -----------------------------------------------------------------------------
// bitty_ls_unit
// Load/store execution stage of the bitty processor. Takes one en_ls request
// from the control unit, runs a single req/ack transaction on the data-memory
// bus, then pulses ls_done. Load data is kept on load_data for write-back.
//  clk        in   clock
//  reset      in   synchronous, active-low reset
//  en_ls      in   01 load, 10 store, 00 idle, 11 illegal (error, no access)
//  ls_addr    in   operand-bus address; only the low ADDR_W bits reach memory
//  ls_wdata   in   store data
//  ls_done    out  one-cycle completion pulse
//  ls_err     out  valid with ls_done: timeout or illegal en_ls
//  load_data  out  last successfully loaded word
//  busy       out  transaction in flight
//  mem        if   data-memory bus, master side
// ADDR_W must not exceed the operand bus width (16).
// -----------------------------------------------------------------------------
module bitty_ls_unit
   import bitty_ls_unit_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               en_ls,
   input  logic [LS_ADDR_BUS_W-1:0] ls_addr,
   input  logic [DATA_W-1:0]        ls_wdata,
   output logic                     ls_done,
   output logic                     ls_err,
   output logic [DATA_W-1:0]        load_data,
   output logic                     busy,
   bitty_ls_unit_if.master          mem
);

   ls_state_e         state_q, state_d;
   logic              ls_done_q, ls_done_d;
   logic              ls_err_q, ls_err_d;
   logic [DATA_W-1:0] load_data_q, load_data_d;
   logic              busy_q, busy_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic timer_clr;
   logic timer_en;
   logic timer_expired;

   // Upper operand-bus bits beyond the memory address width are simply dropped.
   if (ADDR_W < LS_ADDR_BUS_W) begin : g_addr_trunc
      logic unused_addr_hi;
      assign unused_addr_hi = ^ls_addr[LS_ADDR_BUS_W-1:ADDR_W];
   end

   // The timer expires after TIMEOUT BUSY cycles: it starts at 0 in the first
   // BUSY cycle, so the expiry compare is against TIMEOUT-1.
   bitty_ls_timer #(
      .LIMIT  ((TIMEOUT == 0) ? 0 : TIMEOUT - 1),
      .ENABLE (TIMEOUT != 0)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (timer_expired)
   );

   always_comb begin
      state_d     = state_q;
      load_data_d = load_data_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ls_err_d    = 1'b0;
      timer_clr   = 1'b0;
      timer_en    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (is_mem_op(en_ls)) begin
               state_d     = BUSY;
               timer_clr   = 1'b1;
               mem_we_d    = (en_ls == EN_LS_STORE);
               mem_addr_d  = ls_addr[ADDR_W-1:0];
               mem_wdata_d = ls_wdata;
            end else if (en_ls == EN_LS_ILLEGAL) begin
               state_d  = DONE;
               ls_err_d = 1'b1;
            end
         end
         BUSY: begin
            timer_en = 1'b1;
            // Ack is checked first so it wins over a coincident expiry.
            if (mem.mem_ack) begin
               state_d = DONE;
               if (!mem_we_q) begin
                  load_data_d = mem.mem_rdata;
               end
            end else if (timer_expired) begin
               state_d  = DONE;
               ls_err_d = 1'b1;
            end
         end
         DONE: begin
            state_d = (en_ls != EN_LS_IDLE) ? RELEASE : IDLE;
         end
         RELEASE: begin
            // Holding en_ls must not start a second transaction.
            if (en_ls == EN_LS_IDLE) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered copies of the next-state decode so they line
      // up with the state they describe.
      busy_d    = (state_d == BUSY);
      mem_req_d = (state_d == BUSY);
      ls_done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         ls_done_q   <= 1'b0;
         ls_err_q    <= 1'b0;
         load_data_q <= '0;
         busy_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ls_done_q   <= ls_done_d;
         ls_err_q    <= ls_err_d;
         load_data_q <= load_data_d;
         busy_q      <= busy_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign ls_done       = ls_done_q;
   assign ls_err        = ls_err_q;
   assign load_data     = load_data_q;
   assign busy          = busy_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_bitty_ls_unit.sv
// -----------------------------------------------------------------------------
// tb_bitty_ls_unit
// Directed bench for bitty_ls_unit (ADDR_W = 12, TIMEOUT = 4). Inputs change
// and outputs are sampled on the falling clock edge; the memory side of the
// bus is driven directly by each scenario task.
// -----------------------------------------------------------------------------
module tb_bitty_ls_unit;
   import bitty_ls_unit_pkg::*;

   localparam int AW = 12;
   localparam int DW = 16;
   localparam int TO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     reset;
   logic [1:0]               en_ls;
   logic [LS_ADDR_BUS_W-1:0] ls_addr;
   logic [DW-1:0]            ls_wdata;
   logic                     ls_done;
   logic                     ls_err;
   logic [DW-1:0]            load_data;
   logic                     busy;

   int n_cmp = 0;
   int n_bad = 0;

   bitty_ls_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

   bitty_ls_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .en_ls     (en_ls),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_done   (ls_done),
      .ls_err    (ls_err),
      .load_data (load_data),
      .busy      (busy),
      .mem       (mem_if)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; en_ls = EN_LS_IDLE; ls_addr = '0; ls_wdata = '0;
      mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
      tick(); tick();
      n_cmp++;
      if ({ls_done, ls_err, busy, mem_if.mem_req, mem_if.mem_we} !== 5'b00000) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 00000",
                  {ls_done, ls_err, busy, mem_if.mem_req, mem_if.mem_we});
      end
      n_cmp++;
      if (load_data !== 16'h0000) begin
         n_bad++; $display("FAIL reset_load_data: got %h want 0000", load_data);
      end
      n_cmp++;
      if ({mem_if.mem_addr, mem_if.mem_wdata} !== 28'h0) begin
         n_bad++; $display("FAIL reset_bus: got addr %h wdata %h want 0", mem_if.mem_addr, mem_if.mem_wdata);
      end
      n_cmp++;
      if (dut.state_q !== IDLE) begin
         n_bad++; $display("FAIL reset_state: got %b want 00", dut.state_q);
      end
      reset = 1'b1;
      tick();
      $display("txn reset done");
   endtask

   task automatic test_zero_wait_load();
      mem_if.mem_rdata = 16'hBEEF; mem_if.mem_ack = 1'b1;
      ls_addr = 16'h0040; en_ls = EN_LS_LOAD;
      tick();
      n_cmp++;
      if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, ls_done} !== {1'b1, 1'b0, 12'h040, 1'b0}) begin
         n_bad++;
         $display("FAIL load_req: got req %b we %b addr %h done %b want 1 0 040 0",
                  mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, ls_done);
      end
      en_ls = EN_LS_IDLE;
      tick();
      n_cmp++;
      if ({ls_done, ls_err, mem_if.mem_req} !== 3'b100) begin
         n_bad++; $display("FAIL load_done_latency: got done/err/req %b want 100", {ls_done, ls_err, mem_if.mem_req});
      end
      n_cmp++;
      if (load_data !== 16'hBEEF) begin
         n_bad++; $display("FAIL load_data: got %h want beef", load_data);
      end
      mem_if.mem_ack = 1'b0;
      tick();
      n_cmp++;
      if (ls_done !== 1'b0) begin
         n_bad++; $display("FAIL load_done_pulse: got %b want 0", ls_done);
      end
      $display("txn load addr=040 data=%h err=0", load_data);
   endtask

   task automatic test_store_wait();
      mem_if.mem_rdata = 16'hDEAD; mem_if.mem_ack = 1'b0;
      ls_addr = 16'h0012; ls_wdata = 16'h1234; en_ls = EN_LS_STORE;
      for (int i = 1; i <= 4; i++) begin
         tick();
         // Operand changes during BUSY must not disturb the latched access.
         if (i == 1) begin
            en_ls = EN_LS_LOAD; ls_addr = 16'h0777; ls_wdata = 16'h0000;
         end
         n_cmp++;
         if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, ls_done}
             !== {1'b1, 1'b1, 12'h012, 16'h1234, 1'b0}) begin
            n_bad++;
            $display("FAIL store_req_cycle%0d: got req %b we %b addr %h wdata %h done %b want 1 1 012 1234 0",
                     i, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, ls_done);
         end
         if (i == 4) mem_if.mem_ack = 1'b1;
      end
      tick();
      n_cmp++;
      if ({ls_done, ls_err, mem_if.mem_req} !== 3'b100) begin
         n_bad++; $display("FAIL store_done: got done/err/req %b want 100", {ls_done, ls_err, mem_if.mem_req});
      end
      n_cmp++;
      if (load_data !== 16'hBEEF) begin
         n_bad++; $display("FAIL store_load_data_kept: got %h want beef", load_data);
      end
      mem_if.mem_ack = 1'b0;
      tick();
      n_cmp++;
      if ({ls_done, mem_if.mem_req, busy} !== 3'b000) begin
         n_bad++; $display("FAIL store_release: got done/req/busy %b want 000", {ls_done, mem_if.mem_req, busy});
      end
      en_ls = EN_LS_IDLE;
      tick();
      $display("txn store addr=012 data=1234 waits=3");
   endtask

   task automatic test_timeout();
      mem_if.mem_rdata = 16'h7777; mem_if.mem_ack = 1'b0;
      ls_addr = 16'h0ABC; en_ls = EN_LS_LOAD;
      for (int i = 1; i <= TO; i++) begin
         tick();
         if (i == 1) en_ls = EN_LS_IDLE;
         n_cmp++;
         if ({mem_if.mem_req, ls_done} !== 2'b10) begin
            n_bad++; $display("FAIL timeout_busy_cycle%0d: got req/done %b want 10", i, {mem_if.mem_req, ls_done});
         end
      end
      tick();
      n_cmp++;
      if ({mem_if.mem_req, ls_done, ls_err} !== 3'b011) begin
         n_bad++; $display("FAIL timeout_done: got req/done/err %b want 011", {mem_if.mem_req, ls_done, ls_err});
      end
      n_cmp++;
      if (load_data !== 16'hBEEF) begin
         n_bad++; $display("FAIL timeout_load_data_kept: got %h want beef", load_data);
      end
      tick();
      n_cmp++;
      if (ls_done !== 1'b0) begin
         n_bad++; $display("FAIL timeout_done_pulse: got %b want 0", ls_done);
      end
      $display("txn load addr=abc timeout err=1");
   endtask

   task automatic test_held_en_ls();
      int   txns = 0;
      int   dones = 0;
      logic prev_req = 1'b0;
      mem_if.mem_rdata = 16'h5A5A; mem_if.mem_ack = 1'b1;
      ls_addr = 16'h0041; en_ls = EN_LS_LOAD;
      // 2 cycles to ls_done, then 6 more with en_ls still held.
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (mem_if.mem_req && !prev_req) txns++;
         prev_req = mem_if.mem_req;
         if (ls_done) dones++;
      end
      n_cmp++;
      if (txns !== 1) begin
         n_bad++; $display("FAIL held_txn_count: got %0d want 1", txns);
      end
      n_cmp++;
      if (dones !== 1) begin
         n_bad++; $display("FAIL held_done_count: got %0d want 1", dones);
      end
      n_cmp++;
      if (load_data !== 16'h5A5A) begin
         n_bad++; $display("FAIL held_load_data: got %h want 5a5a", load_data);
      end
      n_cmp++;
      if (dut.state_q !== RELEASE) begin
         n_bad++; $display("FAIL held_state: got %b want 11", dut.state_q);
      end
      en_ls = EN_LS_IDLE; mem_if.mem_ack = 1'b0;
      tick();
      n_cmp++;
      if (dut.state_q !== IDLE) begin
         n_bad++; $display("FAIL held_resume_idle: got %b want 00", dut.state_q);
      end
      $display("txn load addr=041 data=%h held_en_ls", load_data);
   endtask

   task automatic test_reset_mid_busy();
      int dones = 0;
      mem_if.mem_rdata = 16'h9999; mem_if.mem_ack = 1'b0;
      ls_addr = 16'h0100; en_ls = EN_LS_LOAD;
      tick();
      n_cmp++;
      if (mem_if.mem_req !== 1'b1) begin
         n_bad++; $display("FAIL rst_busy_req: got %b want 1", mem_if.mem_req);
      end
      reset = 1'b0; en_ls = EN_LS_IDLE;
      tick();
      n_cmp++;
      if ({ls_done, ls_err, busy, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, load_data}
          !== 49'h0) begin
         n_bad++;
         $display("FAIL rst_busy_outputs: got done %b err %b busy %b req %b addr %h load %h want all 0",
                  ls_done, ls_err, busy, mem_if.mem_req, mem_if.mem_addr, load_data);
      end
      n_cmp++;
      if (dut.state_q !== IDLE) begin
         n_bad++; $display("FAIL rst_busy_state: got %b want 00", dut.state_q);
      end
      reset = 1'b1; mem_if.mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ls_done) dones++;
      end
      n_cmp++;
      if ({dones != 0, mem_if.mem_req, busy, load_data} !== 19'h0) begin
         n_bad++;
         $display("FAIL rst_late_ack: got dones %0d req %b busy %b load %h want 0 0 0 0000",
                  dones, mem_if.mem_req, busy, load_data);
      end
      mem_if.mem_ack = 1'b0;
      $display("txn load addr=100 aborted by reset");
   endtask

   task automatic test_illegal_idle();
      int   reqs = 0;
      int   dones = 0;
      logic err_at_done = 1'b0;
      mem_if.mem_ack = 1'b0;
      en_ls = EN_LS_ILLEGAL;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (mem_if.mem_req) reqs++;
         if (ls_done) begin
            dones++;
            err_at_done = ls_err;
         end
         if (i == 2) en_ls = EN_LS_IDLE;
      end
      n_cmp++;
      if (dones !== 1) begin
         n_bad++; $display("FAIL illegal_done_count: got %0d want 1", dones);
      end
      n_cmp++;
      if (err_at_done !== 1'b1) begin
         n_bad++; $display("FAIL illegal_err: got %b want 1", err_at_done);
      end
      n_cmp++;
      if (reqs !== 0) begin
         n_bad++; $display("FAIL illegal_no_req: got %0d req cycles want 0", reqs);
      end
      $display("txn illegal en_ls=11 err=1");
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hFFFF;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_cmp++;
         if ({ls_done, busy, mem_if.mem_req, load_data} !== 19'h0) begin
            n_bad++;
            $display("FAIL stray_ack_cycle%0d: got done %b busy %b req %b load %h want 0 0 0 0000",
                     i, ls_done, busy, mem_if.mem_req, load_data);
         end
      end
      mem_if.mem_ack = 1'b0;
      $display("txn idle with stray ack ignored");
   endtask

   task automatic test_addr_trunc();
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h4321;
      ls_addr = 16'hF123; ls_wdata = 16'hCAFE; en_ls = EN_LS_STORE;
      tick();
      n_cmp++;
      if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata} !== {1'b1, 1'b1, 12'h123, 16'hCAFE}) begin
         n_bad++;
         $display("FAIL trunc_req: got req %b we %b addr %h wdata %h want 1 1 123 cafe",
                  mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata);
      end
      en_ls = EN_LS_IDLE;
      tick();
      n_cmp++;
      if ({ls_done, ls_err, load_data} !== {1'b1, 1'b0, 16'h0000}) begin
         n_bad++; $display("FAIL trunc_done: got done %b err %b load %h want 1 0 0000", ls_done, ls_err, load_data);
      end
      mem_if.mem_ack = 1'b0;
      tick();
      $display("txn store addr=f123->123 data=cafe");
   endtask

   task automatic test_back_to_back();
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h1111;
      ls_addr = 16'h0002; en_ls = EN_LS_LOAD;
      tick();
      en_ls = EN_LS_IDLE;
      tick();
      n_cmp++;
      if ({ls_done, load_data} !== {1'b1, 16'h1111}) begin
         n_bad++; $display("FAIL b2b_first: got done %b load %h want 1 1111", ls_done, load_data);
      end
      $display("txn load addr=002 data=%h", load_data);
      tick();
      mem_if.mem_rdata = 16'h2222; ls_addr = 16'h0003; en_ls = EN_LS_LOAD;
      tick();
      n_cmp++;
      if ({mem_if.mem_req, mem_if.mem_addr} !== {1'b1, 12'h003}) begin
         n_bad++; $display("FAIL b2b_second_req: got req %b addr %h want 1 003", mem_if.mem_req, mem_if.mem_addr);
      end
      en_ls = EN_LS_IDLE;
      tick();
      n_cmp++;
      if ({ls_done, ls_err, load_data} !== {1'b1, 1'b0, 16'h2222}) begin
         n_bad++; $display("FAIL b2b_second: got done %b err %b load %h want 1 0 2222", ls_done, ls_err, load_data);
      end
      mem_if.mem_ack = 1'b0;
      tick();
      $display("txn load addr=003 data=%h", load_data);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_zero_wait_load();
      test_store_wait();
      test_timeout();
      test_held_en_ls();
      test_reset_mid_busy();
      test_illegal_idle();
      test_addr_trunc();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
